// File: rtl/text_pkg.sv
// Shared token, state and glyph definitions for the character-RAM writer.
// The glyph width matches draw_letter's select_letter input.
package text_pkg;

   localparam int GLYPH_W = 6;
   localparam logic [GLYPH_W-1:0] BLANK_GLYPH = 6'h3F;

   typedef enum logic [1:0] {
      CMD_PUT       = 2'd0,
      CMD_NEWLINE   = 2'd1,
      CMD_BACKSPACE = 2'd2,
      CMD_CLEAR     = 2'd3
   } tok_cmd_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } wr_state_t;

endpackage

// File: rtl/cursor_counter.sv
// Text cursor column/row register with advance, retreat, newline and home controls.
// The next-position outputs let the writer address a cell before the cursor register updates.
module cursor_counter #(
   parameter int COLS = 16,
   parameter int ROWS = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_inc,
   input  logic                    i_dec,
   input  logic                    i_nl,
   input  logic                    i_zero,
   output logic [$clog2(COLS)-1:0] o_col,
   output logic [$clog2(ROWS)-1:0] o_row,
   output logic [$clog2(COLS)-1:0] o_col_nxt,
   output logic [$clog2(ROWS)-1:0] o_row_nxt
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [ROW_W-1:0] w_row_up;

   always_comb begin
      w_row_up  = (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      o_col_nxt = r_col;
      o_row_nxt = r_row;
      if (i_zero) begin
         o_col_nxt = '0;
         o_row_nxt = '0;
      end else if (i_inc) begin
         if (r_col == COL_MAX) begin
            o_col_nxt = '0;
            o_row_nxt = w_row_up;
         end else begin
            o_col_nxt = r_col + 1'b1;
         end
      end else if (i_dec) begin
         // Retreat stops at the home cell; it never wraps backwards past (0,0).
         if (r_col != '0) begin
            o_col_nxt = r_col - 1'b1;
         end else if (r_row != '0) begin
            o_col_nxt = COL_MAX;
            o_row_nxt = r_row - 1'b1;
         end
      end else if (i_nl) begin
         o_col_nxt = '0;
         o_row_nxt = w_row_up;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else begin
         r_col <= o_col_nxt;
         r_row <= o_row_nxt;
      end
   end

   assign o_col = r_col;
   assign o_row = r_row;

endmodule

// File: rtl/text_buffer_writer.sv
// Token-driven writer for the character-cell RAM: PUT/NEWLINE/BACKSPACE at one per
// cycle, CLEAR as a one-cell-per-cycle blank sweep with the token port locked out.
module text_buffer_writer
   import text_pkg::*;
#(
   parameter int COLS   = 16,
   parameter int ROWS   = 8,
   parameter int ADDR_W = $clog2(COLS * ROWS)
) (
   input  logic                    pixel_clk_in,
   input  logic                    rst_n_in,
   input  logic                    tok_valid_in,
   output logic                    tok_ready_out,
   input  logic [1:0]              tok_cmd_in,
   input  logic [GLYPH_W-1:0]      tok_letter_in,
   output logic                    wr_en_out,
   output logic [ADDR_W-1:0]       wr_addr_out,
   output logic [GLYPH_W-1:0]      wr_data_out,
   output logic [$clog2(COLS)-1:0] cursor_col_out,
   output logic [$clog2(ROWS)-1:0] cursor_row_out,
   output logic                    busy_out
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

   wr_state_t            r_state, w_state_nxt;
   logic                 r_ready;
   logic                 r_wr_en, w_wr_en_nxt;
   logic [ADDR_W-1:0]    r_wr_addr, w_wr_addr_nxt;
   logic [GLYPH_W-1:0]   r_wr_data, w_wr_data_nxt;
   logic                 w_accept;
   logic                 w_inc, w_dec, w_nl, w_zero;
   logic [COL_W-1:0]     w_col, w_col_nxt;
   logic [ROW_W-1:0]     w_row, w_row_nxt;

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [COL_W-1:0] col,
                                                   input logic [ROW_W-1:0] row);
      return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
   endfunction

   cursor_counter #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_cursor (
      .i_clk     (pixel_clk_in),
      .i_rst_n   (rst_n_in),
      .i_inc     (w_inc),
      .i_dec     (w_dec),
      .i_nl      (w_nl),
      .i_zero    (w_zero),
      .o_col     (w_col),
      .o_row     (w_row),
      .o_col_nxt (w_col_nxt),
      .o_row_nxt (w_row_nxt)
   );

   assign w_accept = tok_valid_in && r_ready;

   always_comb begin
      w_state_nxt   = r_state;
      w_wr_en_nxt   = 1'b0;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_inc         = 1'b0;
      w_dec         = 1'b0;
      w_nl          = 1'b0;
      w_zero        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (tok_cmd_t'(tok_cmd_in))
                  CMD_PUT: begin
                     w_wr_en_nxt   = 1'b1;
                     w_wr_addr_nxt = cell_addr(w_col, w_row);
                     w_wr_data_nxt = tok_letter_in;
                     w_inc         = 1'b1;
                  end
                  CMD_NEWLINE: w_nl = 1'b1;
                  CMD_BACKSPACE: begin
                     if ((w_col != '0) || (w_row != '0)) begin
                        w_dec         = 1'b1;
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = cell_addr(w_col_nxt, w_row_nxt);
                        w_wr_data_nxt = BLANK_GLYPH;
                     end
                  end
                  CMD_CLEAR: begin
                     w_state_nxt   = ST_CLEAR;
                     w_wr_en_nxt   = 1'b1;
                     w_wr_addr_nxt = '0;
                     w_wr_data_nxt = BLANK_GLYPH;
                  end
               endcase
            end
         end
         ST_CLEAR: begin
            // The write-address register doubles as the sweep counter; once the
            // last cell has been issued, spend one cycle homing the cursor.
            if (r_wr_addr == LAST_ADDR) begin
               w_state_nxt = ST_IDLE;
               w_zero      = 1'b1;
            end else begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = r_wr_addr + 1'b1;
               w_wr_data_nxt = BLANK_GLYPH;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_ready   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         // Ready stays low for the cycle spent returning to IDLE after a sweep.
         r_ready   <= (r_state == ST_IDLE) && (w_state_nxt == ST_IDLE);
         r_wr_en   <= w_wr_en_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
      end
   end

   assign tok_ready_out  = r_ready;
   assign wr_en_out      = r_wr_en;
   assign wr_addr_out    = r_wr_addr;
   assign wr_data_out    = r_wr_data;
   assign cursor_col_out = w_col;
   assign cursor_row_out = w_row;
   assign busy_out       = (r_state == ST_CLEAR);

endmodule
